// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with a standard or fall-through read port, occupancy count, almost flags and error pulses.
// Latency: standard mode returns data one cycle after the pop; fall-through shows the head one cycle after the push.
// Backpressure: a push while full is dropped unless a pop is accepted in the same cycle; a pop while empty is dropped; either drop raises a one-cycle error pulse.
module sync_fifo_flex #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int AW        = $clog2(DEPTH),
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_afull,
    output logic              o_aempty,
    output logic [AW:0]       o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [AW-1:0]     wr_idx, rd_idx;
    logic [AW:0]       count;
    logic              empty, full;
    logic              push_ok, pop_ok;

    // Occupancy and status derived from the registered pointers; the wrap bit separates full from empty.
    always_comb begin
        wr_idx = wr_ptr_q[AW-1:0];
        rd_idx = rd_ptr_q[AW-1:0];
        count  = wr_ptr_q - rd_ptr_q;
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    end

    // Accept decision; a pop frees the slot a push into a full FIFO needs.
    always_comb begin
        pop_ok  = i_pop & ~empty;
        push_ok = i_push & (~full | pop_ok);
    end

    // Next pointer and error-pulse state; flush clears everything and suppresses error pulses.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
            ovf_d = i_push & ~push_ok;
            unf_d = i_pop & ~pop_ok;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage write; contents are never cleared, reset and flush only block the write.
    always_ff @(posedge clk) begin
        if (rst_n && !i_flush && push_ok) begin
            mem_q[wr_idx] <= i_data;
        end
    end

    // Status outputs straight from registered state.
    always_comb begin
        o_empty     = empty;
        o_full      = full;
        o_count     = count;
        o_afull     = (count >= AFULL_C);
        o_aempty    = (count <= AEMPTY_C);
        o_overflow  = ovf_q;
        o_underflow = unf_q;
    end

    if (FWFT == 0) begin : g_std
        logic [DATA_W-1:0] rdata_q, rdata_d;
        logic              rvld_q, rvld_d;

        // Capture the head on an accepted pop; hold it otherwise, clear on flush.
        always_comb begin
            rdata_d = rdata_q;
            rvld_d  = 1'b0;
            if (i_flush) begin
                rdata_d = '0;
            end else if (pop_ok) begin
                rdata_d = mem_q[rd_idx];
                rvld_d  = 1'b1;
            end
        end

        // Read data register with synchronous active-low reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q <= '0;
                rvld_q  <= 1'b0;
            end else begin
                rdata_q <= rdata_d;
                rvld_q  <= rvld_d;
            end
        end

        assign o_data  = rdata_q;
        assign o_valid = rvld_q;
    end else begin : g_fwft
        // Head is always presented; the pop acknowledges it.
        assign o_data  = mem_q[rd_idx];
        assign o_valid = ~empty;
    end

endmodule
